bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter, parametrised in input width and BCD digit count.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 tb/tb_bin2bcd_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MAX_DIGITS = 19;

  // Smallest digit count whose decimal range covers every bin_w-bit value.
  function automatic int unsigned bcd_digits(input int unsigned bin_w);
    longint unsigned max_val;
    longint unsigned lim;
    int unsigned     d;
    max_val = (bin_w >= 64) ? '1 : ((64'(1) << bin_w) - 64'(1));
    lim     = 64'(10);
    d       = 1;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (lim <= max_val && d < MAX_DIGITS) begin
        lim = lim * 64'(10);
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted_c
);

  always_comb begin
    adjusted_c = digit;
    if (digit >= DIGIT_W'(5)) begin
      adjusted_c = digit + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, start/ready/done handshake.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 1) begin : g_bad_width
    $error("bin2bcd_seq: BIN_W must be at least 1");
  end
  if (DIGITS < bcd_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to represent 2**BIN_W-1");
  end

  state_t             state;
  state_t             state_next;
  logic [BIN_W-1:0]   shreg;
  logic [BIN_W-1:0]   shreg_next;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_next;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shift;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [BCD_W-1:0]   bcd_next;
  logic               done_next;

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit      (scratch[DIGIT_W*k +: DIGIT_W]),
      .adjusted_c (scratch_adj[DIGIT_W*k +: DIGIT_W])
    );
  end

  // The sizing check guarantees the top bit of scratch_adj is always zero.
  assign scratch_shift = (scratch_adj << 1) | {{(BCD_W-1){1'b0}}, shreg[BIN_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      ready   <= (state_next == IDLE);
      busy    <= (state_next == SHIFT);
      done    <= done_next;
      bcd     <= bcd_next;
      shreg   <= shreg_next;
      scratch <= scratch_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    scratch_next = scratch;
    cnt_next     = cnt;
    bcd_next     = bcd;
    done_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_next   = bin;
          scratch_next = '0;
          cnt_next     = CNT_W'(BIN_W);
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next   = shreg << 1;
        scratch_next = scratch_shift;
        cnt_next     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_next   = scratch_shift;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: an 8-bit/3-digit instance and a 4-bit/2-digit instance.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start8;
  logic [7:0]  bin8;
  logic        ready8, busy8, done8;
  logic [11:0] bcd8;
  logic        start4;
  logic [3:0]  bin4;
  logic        ready4, busy4, done4;
  logic [7:0]  bcd4;

  int vectors;
  int miscompares;
  int done_cnt8;
  int done_cnt4;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .bcd(bcd8)
  );

  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .bcd(bcd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done8) done_cnt8 <= done_cnt8 + 1;
    if (done4) done_cnt4 <= done_cnt4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref8(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Counts cycles from the accepting edge until done is observed, bounded.
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 20);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done4 && n < 20);
  endtask

  task automatic run8(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int n;
    bin8 = v; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_bcd"}, 32'(bcd8), 32'(exp));
  endtask

  initial begin
    int n;
    int d0;
    vectors = 0; miscompares = 0; done_cnt8 = 0; done_cnt4 = 0;
    rst = 1'b1; start8 = 1'b0; bin8 = '0; start4 = 1'b0; bin4 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_bcd", 32'(bcd8), 32'h000);
    check("rst_ready4", 32'(ready4), 32'd1);

    // Zero operand, latency and return to idle
    bin8 = 8'd0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t1_busy", 32'(busy8), 32'd1);
    check("t1_ready", 32'(ready8), 32'd0);
    wait_done8(n);
    check("t1_lat", 32'(n), 32'd8);
    check("t1_bcd", 32'(bcd8), 32'h000);
    check("t1_ready_done", 32'(ready8), 32'd1);
    tick();
    check("t1_done_pulse", 32'(done8), 32'd0);
    check("t1_ready_after", 32'(ready8), 32'd1);

    run8(8'd255, 12'h255, "t2_255");
    run8(8'd99,  12'h099, "t2_99");
    run8(8'd100, 12'h100, "t2_100");
    run8(8'd9,   12'h009, "t2_9");
    tick();

    // Exhaustive, restarting in each done cycle
    d0 = done_cnt8;
    bin8 = 8'd0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wait_done8(n);
      check($sformatf("t3_lat_%0d", i), 32'(n), 32'd8);
      check($sformatf("t3_bcd_%0d", i), 32'(bcd8), 32'(ref8(i)));
      if (i < 255) begin
        bin8 = 8'(i + 1); start8 = 1'b1;
        tick();
        start8 = 1'b0;
      end
    end
    tick();
    check("t3_done_count", 32'(done_cnt8 - d0), 32'd256);

    // start during a conversion is ignored
    d0 = done_cnt8;
    bin8 = 8'd200; start8 = 1'b1;
    tick();
    start8 = 1'b0; bin8 = 8'd55;
    tick(); tick();
    bin8 = 8'd7; start8 = 1'b1;
    tick();
    start8 = 1'b0; bin8 = 8'd0;
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    check("t4_lat_rem", 32'(n), 32'd5);
    check("t4_bcd", 32'(bcd8), 32'h200);
    for (int i = 0; i < 12; i++) tick();
    check("t4_done_count", 32'(done_cnt8 - d0), 32'd1);
    check("t4_ready", 32'(ready8), 32'd1);

    // Reset mid-conversion aborts without a done pulse
    d0 = done_cnt8;
    bin8 = 8'd123; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ready", 32'(ready8), 32'd1);
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_bcd", 32'(bcd8), 32'h000);
    check("t5_done", 32'(done8), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("t5_no_done", 32'(done_cnt8 - d0), 32'd0);

    // Narrow instance reproduces the 4-bit converter
    d0 = done_cnt4;
    for (int i = 0; i < 16; i++) begin
      bin4 = 4'(i); start4 = 1'b1;
      tick();
      start4 = 1'b0;
      wait_done4(n);
      check($sformatf("t6_lat_%0d", i), 32'(n), 32'd4);
      check($sformatf("t6_bcd_%0d", i), 32'(bcd4), 32'({4'((i > 9) ? 1 : 0), 4'(i % 10)}));
    end
    tick();
    check("t6_done_count", 32'(done_cnt4 - d0), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
